// File: rtl/i2s_tx_scheduler.sv
// i2s_tx_scheduler: schedules fixed-length bursts of generator or external words
// onto a registered valid/ready stream towards an I2S sender.
module i2s_tx_scheduler #(
   parameter int DATA_WIDTH = 24,
   parameter int BURST_LEN  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  sel_ext,
   input  logic [DATA_WIDTH-1:0] gen_data,
   output logic                  gen_step,
   input  logic [DATA_WIDTH-1:0] ext_data,
   input  logic                  ext_valid,
   output logic                  ext_ready,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_channel,
   output logic                  active_src,
   output logic                  burst_done,
   output logic [15:0]           underflow_cnt
);
   localparam int IW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [IW-1:0] word_idx;
   logic xfer, last, start, load, src;
   assign tx_channel = word_idx[0];
   always_comb begin
      state_nx  = state;
      start     = (state == IDLE) && enable;
      xfer      = (state == RUN) && tx_ready;
      last      = xfer && (word_idx == IW'(BURST_LEN - 1));
      // the final transfer of a burst preloads the next burst only if enable holds
      load      = rst_n && (start || (xfer && (!last || enable)));
      src       = (state == IDLE || last) ? sel_ext : active_src;
      gen_step  = load && !src;
      ext_ready = load && src && ext_valid;
      if (start)
         state_nx = RUN;
      else if (last && !enable)
         state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         tx_data       <= '0;
         tx_valid      <= 1'b0;
         word_idx      <= '0;
         active_src    <= 1'b0;
         burst_done    <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         state      <= state_nx;
         tx_valid   <= (state_nx == RUN);
         burst_done <= last;
         if (load) begin
            tx_data <= !src ? gen_data : (ext_valid ? ext_data : '0);
            if (src && !ext_valid && underflow_cnt != 16'hFFFF)
               underflow_cnt <= underflow_cnt + 16'd1;
         end
         if (start) begin
            active_src <= sel_ext;
            word_idx   <= '0;
         end else if (xfer) begin
            word_idx <= last ? '0 : word_idx + 1'b1;
            if (last && enable)
               active_src <= sel_ext;
         end
      end
   end
endmodule

// File: doc/i2s_tx_scheduler.md
I2S_TX_SCHEDULER -- requirements
Module: i2s_tx_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 24, SHALL set the sample word width.
REQ-002 Parameter BURST_LEN, default 20, SHALL set words per burst; it SHALL be even and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 enable  input  1  SHALL request bursts; it is sampled only in IDLE and at burst end.
REQ-006 sel_ext  input  1  SHALL select the source for the next burst: 0 = pattern generator, 1 = external stream.
REQ-007 gen_data  input  DATA_WIDTH  SHALL carry the current pattern generator word.
REQ-008 gen_step  output  1  SHALL be a combinational one-cycle pulse that advances the generator.
REQ-009 ext_data  input  DATA_WIDTH  SHALL carry the external stream word.
REQ-010 ext_valid  input  1  SHALL indicate that ext_data is valid.
REQ-011 ext_ready  output  1  SHALL be a combinational pulse that pops ext_data.
REQ-012 tx_data  output  DATA_WIDTH  SHALL be the registered word presented to the I2S sender.
REQ-013 tx_valid  output  1  SHALL be the registered flag indicating that tx_data is valid.
REQ-014 tx_ready  input  1  SHALL be the sender's word accept; a transfer occurs when tx_valid and tx_ready are both 1.
REQ-015 tx_channel  output  1  SHALL give the slot of tx_data: 0 = left, 1 = right.
REQ-016 active_src  output  1  SHALL be the registered source of the current burst.
REQ-017 burst_done  output  1  SHALL be a registered one-cycle pulse marking burst completion.
REQ-018 underflow_cnt  output  16  SHALL count zero words inserted because the external stream was empty.

Function
REQ-019 The block SHALL have two states: IDLE and RUN.
REQ-020 A load SHALL occur in either case below:
- the IDLE cycle in which enable=1;
- any RUN transfer, except the final burst transfer when enable=0.
REQ-021 On a load, the source SHALL be chosen as follows:
- in the IDLE-exit cycle and on the final burst transfer, use sel_ext directly;
- otherwise, use active_src.
REQ-022 On a generator load:
- tx_data SHALL take gen_data;
- gen_step SHALL be 1 in that same cycle;
- ext_ready SHALL be 0.
REQ-023 On an external load with ext_valid=1:
- tx_data SHALL take ext_data;
- ext_ready SHALL be 1 in that same cycle.
REQ-024 On an external load with ext_valid=0:
- tx_data SHALL take 0;
- ext_ready SHALL be 0;
- underflow_cnt SHALL increment, saturating at 16'hFFFF.
REQ-025 gen_step and ext_ready SHALL be 0 in every cycle without a load.
REQ-026 On IDLE with enable=1, the block SHALL, on that edge:
- latch sel_ext into active_src;
- clear word_idx to 0;
- set tx_valid to 1;
- enter RUN.
REQ-027 In RUN, tx_valid SHALL stay 1, and tx_data SHALL hold stable until a transfer occurs.
REQ-028 The internal word_idx SHALL increment on each transfer, wrapping from BURST_LEN-1 to 0; tx_channel SHALL equal word_idx[0].
REQ-029 On the transfer of word BURST_LEN-1, burst_done SHALL be 1 in the following cycle.
REQ-030 On the transfer of word BURST_LEN-1 with enable=1, active_src SHALL take sel_ext, and the next burst SHALL start with no idle cycle.
REQ-031 On the transfer of word BURST_LEN-1 with enable=0, the next state SHALL be IDLE, tx_valid SHALL be 0, and tx_data SHALL hold its last value.
REQ-032 Deasserting enable, or changing sel_ext, mid-burst SHALL have no effect until the burst ends; a started burst SHALL always complete all BURST_LEN words.
REQ-033 tx_ready while tx_valid=0 SHALL be ignored.
REQ-034 tx_ready held at 0 SHALL stall indefinitely, with no loads, pulses or counter changes.

Reset
REQ-035 While rst_n=0, all of the following SHALL be forced immediately, regardless of clk:
- state = IDLE;
- tx_data, word_idx and underflow_cnt = 0;
- tx_valid, tx_channel, active_src and burst_done = 0.
REQ-036 gen_step and ext_ready SHALL be 0 while rst_n=0.
REQ-037 Reset asserted mid-burst SHALL abandon the burst; after release, operation SHALL restart only via IDLE.

Verification
REQ-038 Generator burst: enable=1, sel_ext=0, tx_ready=1 continuously -> expect:
- 20 transfers with 20 gen_step pulses;
- tx_channel alternating 0,1;
- burst_done 1 cycle after the 20th transfer;
- next burst back-to-back.
REQ-039 External underflow: sel_ext=1, ext_valid=0 for words 3-5 -> expect tx_data=0 on those words and underflow_cnt=3, with no ext_ready pulses for those words.
REQ-040 Source switch: flip sel_ext at word 7 of a generator burst -> expect words 8-19 still from the generator, and the word after the boundary from ext_data with active_src=1.
REQ-041 Stop: drop enable at word 10 -> expect all 20 words sent, then tx_valid=0 one cycle after the last transfer, and state IDLE.
REQ-042 Backpressure: tx_ready=0 for 50 cycles mid-burst -> expect tx_data, tx_channel and word_idx frozen, and no gen_step pulses.
REQ-043 Async reset: pulse rst_n low between clock edges at word 12 -> expect all outputs 0 before the next edge, and a fresh burst from word 0 after release with enable=1.
